// File: rtl/f6_bias_act.sv
// F6 bias add, requantise and saturate; biases held in a local register file.
// Optional build macro F6_RELU_EN clamps negative activations to zero.
module f6_bias_act #(
  parameter int WD     = 8,
  parameter int NUM    = 84,
  parameter int AW     = 20,
  parameter int BSHIFT = 4,
  parameter int OSHIFT = 6
) (
  input  logic                 i_sclk,
  input  logic                 i_rst,
  input  logic                 i_b_en,
  input  logic [7:0]           i_b_num,
  input  logic signed [WD-1:0] i_bias,
  input  logic                 i_acc_en,
  input  logic signed [AW-1:0] i_acc,
  output logic                 o_ready,
  output logic                 o_y_en,
  output logic [7:0]           o_y_num,
  output logic signed [WD-1:0] o_y,
  output logic                 o_done,
  output logic                 o_err
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int NW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [7:0] NUM_B = 8'(NUM);

  localparam int YMAXI = 2**(WD-1) - 1;
  localparam int YMINI = -(2**(WD-1));
  localparam logic signed [AW:0] YMAX = YMAXI[AW:0];
  localparam logic signed [AW:0] YMIN = YMINI[AW:0];

  logic [0:0] state;
  logic [7:0] load_cnt;
  logic [7:0] nrn_cnt;

  logic signed [WD-1:0] bias_q [NUM];

  logic                 s1_v;
  logic [7:0]           s1_num;
  logic signed [AW:0]   s1_sum;

  logic                 b_ok;
  logic                 b_wr;
  logic                 acc_go;
  logic [7:0]           b_idx;
  logic signed [WD-1:0] bias_rd;
  logic signed [AW:0]   bias_ext;
  logic signed [AW:0]   acc_ext;
  logic signed [AW:0]   sum_c;
  logic signed [AW:0]   q_c;
  logic signed [WD-1:0] y_c;

  assign b_ok   = (i_b_num != 8'd0) && (i_b_num <= NUM_B);
  assign b_wr   = i_b_en && b_ok;
  assign acc_go = i_acc_en && (state == RUN);
  assign b_idx  = i_b_num - 8'd1;

  assign o_ready = (state == RUN);

  assign bias_rd  = bias_q[nrn_cnt[NW-1:0]];
  assign bias_ext = {{(AW+1-WD){bias_rd[WD-1]}}, bias_rd};
  assign acc_ext  = {i_acc[AW-1], i_acc};
  assign sum_c    = acc_ext + (bias_ext <<< BSHIFT);
  assign q_c      = s1_sum >>> OSHIFT;

  // saturate the requantised sum, then optionally rectify
  always_comb begin
    y_c = q_c[WD-1:0];
    if (q_c > YMAX)
      y_c = YMAX[WD-1:0];
    else if (q_c < YMIN)
      y_c = YMIN[WD-1:0];
`ifdef F6_RELU_EN
    if (y_c[WD-1])
      y_c = '0;
`else
    y_c = y_c;
`endif
  end

  // load/run control, neuron counter and sticky error flag
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state    <= LOAD;
      load_cnt <= 8'd0;
      nrn_cnt  <= 8'd0;
      o_err    <= 1'b0;
    end else begin
      if (i_b_en && !b_ok)
        o_err <= 1'b1;
      if (i_acc_en && (state == LOAD))
        o_err <= 1'b1;
      unique case (state)
        LOAD: begin
          if (b_wr) begin
            if (load_cnt == NUM_B - 8'd1) begin
              state    <= RUN;
              load_cnt <= 8'd0;
            end else begin
              load_cnt <= load_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          if (acc_go) begin
            if (nrn_cnt == NUM_B - 8'd1)
              nrn_cnt <= 8'd0;
            else
              nrn_cnt <= nrn_cnt + 8'd1;
          end
          if (b_wr) begin
            state    <= LOAD;
            load_cnt <= 8'd1;
            nrn_cnt  <= 8'd0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // bias register file; a same-cycle read sees the old value
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM; i++)
        bias_q[i] <= '0;
    end else if (b_wr) begin
      bias_q[b_idx[NW-1:0]] <= i_bias;
    end
  end

  // stage 1: bias alignment and add
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      s1_v   <= 1'b0;
      s1_num <= 8'd0;
      s1_sum <= '0;
    end else begin
      s1_v <= acc_go;
      if (acc_go) begin
        s1_sum <= sum_c;
        s1_num <= nrn_cnt + 8'd1;
      end
    end
  end

  // stage 2: registered activation output
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      o_y_en  <= 1'b0;
      o_y_num <= 8'd0;
      o_y     <= '0;
      o_done  <= 1'b0;
    end else begin
      o_y_en <= s1_v;
      o_done <= s1_v && (s1_num == NUM_B);
      if (s1_v) begin
        o_y     <= y_c;
        o_y_num <= s1_num;
      end
    end
  end

endmodule
